// File: rtl/eespfal_pclk_sequencer_if.sv
// eespfal_pclk_sequencer_if: run handshake and per-rail power-clock control bundle
interface eespfal_pclk_sequencer_if #(parameter int WAVE_W = 16);
  logic start;
  logic abort;
  logic [WAVE_W-1:0] n_waves;
  logic busy;
  logic done;
  logic [3:0] rise_en;
  logic [3:0] hold_en;
  logic [3:0] fall_en;
  logic [3:0] Dis;
  logic [WAVE_W-1:0] wave_cnt;
  modport master(output start, abort, n_waves, input busy, done, rise_en, hold_en, fall_en, Dis, wave_cnt);
  modport slave(input start, abort, n_waves, output busy, done, rise_en, hold_en, fall_en, Dis, wave_cnt);
endinterface

// File: rtl/eespfal_pclk_sequencer.sv
// eespfal_pclk_sequencer: 4-phase trapezoidal power-clock sequencer for cascaded EESPFAL stages
module eespfal_pclk_sequencer #(
  parameter int STEP_CYC = 4,
  parameter int DIS_CYC  = 2,
  parameter int WAVE_W   = 16
) (
  input logic CLK,
  input logic RST,
  eespfal_pclk_sequencer_if.slave bus
);
  localparam int TW = $clog2(STEP_CYC);
  localparam int GW = WAVE_W + 3;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [TW-1:0] t, t_nx;
  logic [GW-1:0] g, g_nx, span;
  logic [WAVE_W-1:0] n, n_nx, cnt, cnt_nx;
  logic done_q, done_nx, last_t;
  logic [3:0] act, rise, hold, fall, dis;
  logic [1:0] seg [4];
  assign span = {1'b0, n, 2'b00};
  assign last_t = t == TW'(STEP_CYC - 1);
  // rail k runs 4N segments starting at global segment k; outputs decode only registered state
  for (genvar k = 0; k < 4; k++) begin : rail
    assign act[k]  = state == RUN && g >= GW'(k) && g < span + GW'(k);
    assign seg[k]  = g[1:0] - 2'(k);
    assign rise[k] = act[k] && seg[k] == 2'd0;
    assign hold[k] = act[k] && seg[k] == 2'd1;
    assign fall[k] = act[k] && seg[k] == 2'd2;
    assign dis[k]  = !act[k] || (seg[k] == 2'd3 && 32'(t) < DIS_CYC);
  end
  // state register; wave_cnt survives abort and is cleared only by reset or a new run
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      t      <= '0;
      g      <= '0;
      n      <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      t      <= t_nx;
      g      <= g_nx;
      n      <= n_nx;
      cnt    <= cnt_nx;
      done_q <= done_nx;
    end
  end
  // next state: accept start in IDLE (abort wins), step tick/segment counters, finish after rail 3 drains
  always_comb begin
    state_nx = state;
    t_nx     = t;
    g_nx     = g;
    n_nx     = n;
    cnt_nx   = cnt;
    done_nx  = 1'b0;
    if (state == IDLE) begin
      if (bus.start && !bus.abort) begin
        if (bus.n_waves != '0) begin
          state_nx = RUN;
          t_nx     = '0;
          g_nx     = '0;
          n_nx     = bus.n_waves;
          cnt_nx   = '0;
        end else done_nx = 1'b1;
      end
    end else if (bus.abort) state_nx = IDLE;
    else begin
      t_nx = last_t ? '0 : t + 1'b1;
      g_nx = last_t ? g + 1'b1 : g;
      if (last_t && act[3] && seg[3] == 2'd3 && !(&cnt)) cnt_nx = cnt + 1'b1;
      if (last_t && g == span + GW'(2)) begin
        state_nx = IDLE;
        done_nx  = 1'b1;
      end
    end
  end
  assign bus.busy     = state == RUN;
  assign bus.done     = done_q;
  assign bus.rise_en  = rise;
  assign bus.hold_en  = hold;
  assign bus.fall_en  = fall;
  assign bus.Dis      = dis;
  assign bus.wave_cnt = cnt;
endmodule

// File: tb/tb_eespfal_pclk_sequencer.sv
// tb_eespfal_pclk_sequencer: scoreboard bench for the power-clock sequencer
module tb_eespfal_pclk_sequencer;
  localparam int W = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  eespfal_pclk_sequencer_if #(.WAVE_W(W)) bus();
  eespfal_pclk_sequencer #(.STEP_CYC(4), .DIS_CYC(2), .WAVE_W(W)) dut(.CLK(clk), .RST(rst), .bus(bus));
  typedef struct {int c; logic [32:0] v;} snap_t;
  typedef struct {int c; logic [W-1:0] w;} done_t;
  snap_t sq[$];
  done_t dq[$];
  int lq[$];
  int cyc = 0;
  int base = 0;
  int n_chk = 0;
  int n_pass = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, req);
  endtask
  task automatic exp_at(input int rel, input logic [3:0] r, input logic [3:0] h, input logic [3:0] f,
                        input logic [3:0] d, input logic b, input logic [W-1:0] w);
    sq.push_back(snap_t'{base + rel, {r, h, f, d, b, w}});
  endtask
  task automatic exp_done(input int rel, input logic [W-1:0] w);
    dq.push_back(done_t'{base + rel, w});
  endtask
  task automatic launch(input logic [W-1:0] n);
    base = cyc;
    bus.n_waves = n;
    bus.start = 1'b1;
  endtask
  task automatic wave1();
    launch(1);
    exp_at(1, 4'b0001, 4'b0000, 4'b0000, 4'b1110, 1, 0);
    exp_at(5, 4'b0010, 4'b0001, 4'b0000, 4'b1100, 1, 0);
    exp_at(9, 4'b0100, 4'b0010, 4'b0001, 4'b1000, 1, 0);
    exp_at(13, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 1, 0);
    exp_at(15, 4'b1000, 4'b0100, 4'b0010, 4'b0000, 1, 0);
    exp_at(17, 4'b0000, 4'b1000, 4'b0100, 4'b0011, 1, 0);
    exp_at(28, 4'b0000, 4'b0000, 4'b0000, 4'b0111, 1, 0);
    exp_at(29, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 0, 1);
    exp_done(29, 1);
    lq.push_back(28);
    @(negedge clk) bus.start = 1'b0;
    repeat (31) @(negedge clk);
  endtask
  // monitor: per-cycle invariants, cycle-stamped snapshots, done events and busy run lengths
  initial begin
    logic [32:0] act;
    snap_t e;
    done_t d;
    int blen;
    int want;
    blen = 0;
    forever begin
      @(posedge clk);
      #1;
      act = {bus.rise_en, bus.hold_en, bus.fall_en, bus.Dis, bus.busy, bus.wave_cnt};
      chk(((bus.rise_en & bus.hold_en) | (bus.rise_en & bus.fall_en) | (bus.hold_en & bus.fall_en)) == 4'd0 &&
          (bus.Dis & (bus.rise_en | bus.hold_en | bus.fall_en)) == 4'd0, "invariant", 64'(act), 64'(0));
      while (sq.size() > 0 && sq[0].c <= cyc) begin
        e = sq.pop_front();
        chk(e.c == cyc && act == e.v, "snapshot", 64'(act), 64'(e.v));
      end
      if (bus.done) begin
        if (dq.size() == 0) chk(1'b0, "done_unexpected", 64'(1), 64'(0));
        else begin
          d = dq.pop_front();
          chk(d.c == cyc && d.w == bus.wave_cnt, "done", 64'({cyc, bus.wave_cnt}), 64'({d.c, d.w}));
        end
      end
      if (bus.busy) blen++;
      else if (blen > 0) begin
        want = lq.size() > 0 ? lq.pop_front() : -1;
        chk(blen == want, "busy_len", 64'(blen), 64'(want));
        blen = 0;
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.n_waves = '0;
    repeat (3) @(negedge clk);
    base = cyc;
    exp_at(1, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 0, 0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    wave1();
    launch(3);
    exp_at(1, 4'b0001, 4'b0000, 4'b0000, 4'b1110, 1, 0);
    exp_at(17, 4'b0001, 4'b1000, 4'b0100, 4'b0010, 1, 0);
    exp_at(21, 4'b0010, 4'b0001, 4'b1000, 4'b0100, 1, 0);
    exp_at(29, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 1, 1);
    exp_at(33, 4'b0001, 4'b1000, 4'b0100, 4'b0010, 1, 1);
    exp_at(45, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 1, 2);
    exp_at(49, 4'b0000, 4'b1000, 4'b0100, 4'b0011, 1, 2);
    exp_at(60, 4'b0000, 4'b0000, 4'b0000, 4'b0111, 1, 2);
    exp_at(61, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 0, 3);
    exp_done(61, 3);
    lq.push_back(60);
    @(negedge clk) bus.start = 1'b0;
    repeat (63) @(negedge clk);
    launch(0);
    exp_at(1, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 0, 3);
    exp_at(2, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 0, 3);
    exp_done(1, 3);
    @(negedge clk) bus.start = 1'b0;
    repeat (4) @(negedge clk);
    launch(2);
    exp_at(1, 4'b0001, 4'b0000, 4'b0000, 4'b1110, 1, 0);
    exp_at(44, 4'b0000, 4'b0000, 4'b0000, 4'b0111, 1, 1);
    exp_at(45, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 0, 2);
    exp_at(46, 4'b0001, 4'b0000, 4'b0000, 4'b1110, 1, 0);
    exp_at(90, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 0, 2);
    exp_at(92, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 0, 2);
    exp_done(45, 2);
    exp_done(90, 2);
    lq.push_back(44);
    lq.push_back(44);
    repeat (47) @(negedge clk);
    bus.start = 1'b0;
    bus.n_waves = 5;
    repeat (45) @(negedge clk);
    launch(2);
    exp_at(10, 4'b0100, 4'b0010, 4'b0001, 4'b1000, 1, 0);
    exp_at(11, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 0, 0);
    exp_at(12, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 0, 0);
    exp_at(13, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 0, 0);
    lq.push_back(10);
    @(negedge clk) bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    launch(2);
    exp_at(20, 4'b0001, 4'b1000, 4'b0100, 4'b0000, 1, 0);
    exp_at(21, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 0, 0);
    lq.push_back(20);
    @(negedge clk) bus.start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    wave1();
    repeat (2) @(negedge clk);
    chk(sq.size() == 0, "pending_snapshots", 64'(sq.size()), 64'(0));
    chk(dq.size() == 0, "pending_done", 64'(dq.size()), 64'(0));
    chk(lq.size() == 0, "pending_busy_len", 64'(lq.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/eespfal_pclk_sequencer.md
Name: eespfal_pclk_sequencer

Overview:
Digital sequencer for the 4-phase trapezoidal power-clock rails that drive cascaded EESPFAL gate stages. For each rail k (0..3) it generates ramp-up, hold and ramp-down enables for that rail's stepwise charger, plus the per-rail Dis discharge strobe. Rail k lags rail k-1 by one segment, so data ripples stage-to-stage. A start/done handshake runs a programmed number of evaluation waves, with clean pipeline fill and drain so that no rail ever begins mid-ramp.

Parameters:
STEP_CYC, 4, CLK cycles per segment (rise/hold/fall/wait); legal range >= 2.
DIS_CYC, 2, cycles Dis is asserted at the start of a wait segment; legal range 1..STEP_CYC.
WAVE_W, 16, width of n_waves and wave_cnt.

Ports:
CLK  input  1  system clock; all logic on the rising edge.
RST  input  1  synchronous, active-high reset.
start  input  1  request to run; accepted only in IDLE.
abort  input  1  immediate stop; all rails forced idle.
n_waves  input  WAVE_W  number of full periods per rail; sampled when start is accepted.
busy  output  1  high while a run is in progress.
done  output  1  one-cycle pulse when a run completes normally.
rise_en  output  4  per-rail ramp-up enable.
hold_en  output  4  per-rail hold-at-VDD enable.
fall_en  output  4  per-rail ramp-down (energy recovery) enable.
Dis  output  4  per-rail discharge strobe (drives gate Dis inputs).
wave_cnt  output  WAVE_W  completed periods of rail 3 in the current or most recent run.

Behaviour:
- Clock and reset: one clock, CLK; reset RST is synchronous and active-high.
- Reset values: busy=0, done=0, rise_en=hold_en=fall_en=0, Dis=4'hF, wave_cnt=0, FSM=IDLE.
- RST asserted mid-run returns to reset values on the next edge; no done pulse is generated.
- FSM states: IDLE, RUN.
- Internal counters:
  - Tick counter t, range 0..STEP_CYC-1.
  - Global segment counter G, width WAVE_W+3; G increments when t wraps.
  - Latched count N = n_waves.
- IDLE, start=1, n_waves!=0: on the next edge go to RUN with t=0, G=0, busy=1, wave_cnt=0.
- IDLE, start=1, n_waves==0: stay IDLE; done=1 for one cycle on the next edge; busy stays 0.
- Rail k is active while k <= G < k+4N. Its segment is (G-k) mod 4: 0=rise, 1=hold, 2=fall, 3=wait.
- Active rail outputs:
  - rise_en[k], hold_en[k] and fall_en[k] each high only during its own segment.
  - In the wait segment, Dis[k]=1 while t < DIS_CYC, then 0.
  - Dis[k]=0 during rise, hold and fall.
- Inactive rail: all enables 0 and Dis[k]=1 (rail clamped to GND).
- Invariants, every cycle and every rail:
  - At most one of rise_en/hold_en/fall_en is high.
  - Dis is never high together with any enable.
- Outputs are registered and reflect the current t and G; no combinational paths from inputs.
- wave_cnt increments on the last cycle of each rail-3 wait segment (t=STEP_CYC-1, (G-3) mod 4 = 3); it saturates at all-ones.
- Run length: RUN lasts (4N+3)*STEP_CYC cycles. On the edge after the final cycle (G=4N+2, t=STEP_CYC-1): FSM=IDLE, busy=0, done=1 for exactly one cycle.
- start while busy is ignored; n_waves changes during RUN have no effect.
- abort=1 in RUN:
  - Next edge: FSM=IDLE, busy=0, all enables 0, Dis=4'hF, no done pulse.
  - wave_cnt holds its value.
- abort in IDLE has no effect. abort and start in the same IDLE cycle: abort wins, and start is not accepted.

Test Plan:
- Single wave (STEP_CYC=4, DIS_CYC=2, n_waves=1, start accepted at cycle 0):
  - rail0 rise cycles 1-4, hold 5-8, fall 9-12, wait 13-16 with Dis[0]=1 at 13-14 and 0 at 15-16.
  - rail3 rise 13-16; rail3 wait ends at cycle 28.
  - done=1 at cycle 29, busy=0 from 29, wave_cnt=1.
- Multi-wave (n_waves=3): rail0 shows 3 rise pulses 16 cycles apart; busy high for 60 cycles; wave_cnt increments 1→2→3; invariants are checked every cycle.
- Zero waves (n_waves=0): done pulse at cycle 1, busy never high, Dis stays 4'hF, no enable toggles.
- start held high throughout a run with n_waves=2: exactly one run occurs; a second run starts only after the done cycle, and only if start is still high in IDLE.
- abort at cycle 10 of an n_waves=2 run: at cycle 11 all enables=0, Dis=4'hF, busy=0, no done pulse, wave_cnt=0.
- RST asserted at cycle 20 of a run: at cycle 21 all outputs equal reset values; a new start after RST deasserts restarts cleanly with G=0.
